// File: rtl/trinum_pkg.sv
// trinum_pkg: shared state encoding and default widths for the triangular-root block
package trinum_pkg;

    // 2'd3 is unused and the FSM treats it exactly like IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SW_DEF = 7;
    localparam int NW_DEF = 4;

endpackage

// File: rtl/trinum_step.sv
// trinum_step: one subtraction step, compares acc against i and forms acc - i
module trinum_step #(
    parameter int SW = 7,
    parameter int NW = 4
) (
    input  logic [SW-1:0] acc,
    input  logic [NW:0]   i,
    output logic          ge,
    output logic [SW-1:0] diff
);

    // compare in a width wide enough for both operands so neither is truncated
    localparam int W = (SW > NW + 1) ? SW : NW + 1;

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_d;

    assign w_a  = W'(acc);
    assign w_b  = W'(i);
    assign w_d  = w_a - w_b;
    assign ge   = w_a >= w_b;
    assign diff = w_d[SW-1:0];

endmodule

// File: rtl/trinum_root.sv
// trinum_root: sequential inverse of the triangular sum by repeated subtraction
module trinum_root
    import trinum_pkg::*;
#(
    parameter int SW = SW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] s_in,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] n_out,
    output logic [SW-1:0] rem_out,
    output logic          exact
);

    state_t        r_state;
    logic [SW-1:0] r_acc;
    logic [NW:0]   r_i;
    logic [NW-1:0] r_n;
    logic          r_busy;
    logic          r_done;
    logic [NW-1:0] r_n_out;
    logic [SW-1:0] r_rem;
    logic          r_exact;
    logic          w_ge;
    logic [SW-1:0] w_diff;

    trinum_step #(
        .SW(SW),
        .NW(NW)
    ) u_step (
        .acc (r_acc),
        .i   (r_i),
        .ge  (w_ge),
        .diff(w_diff)
    );

    // FSM: latch S on start, subtract 1,2,3,... until the next step would go negative
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_i     <= '0;
            r_n     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_n_out <= '0;
            r_rem   <= '0;
            r_exact <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_ge) begin
                        r_acc <= w_diff;
                        r_n   <= r_i[NW-1:0];
                        r_i   <= r_i + (NW+1)'(1);
                    end else begin
                        r_n_out <= r_n;
                        r_rem   <= r_acc;
                        r_exact <= (r_acc == '0);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= start;
                    if (start) begin
                        r_acc   <= s_in;
                        r_i     <= (NW+1)'(1);
                        r_n     <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign n_out   = r_n_out;
    assign rem_out = r_rem;
    assign exact   = r_exact;

endmodule

// File: tb/tb_trinum_root.sv
// tb_trinum_root: randomized scoreboard bench for trinum_root against an arithmetic model
module tb_trinum_root;

    localparam int SW = 7;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] s_in = '0;
    logic          busy;
    logic          done;
    logic [NW-1:0] n_out;
    logic [SW-1:0] rem_out;
    logic          exact;

    typedef struct {
        int s;
        int n;
        int rem;
        int ex;
        int acc_edge;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;

    trinum_root #(
        .SW(SW),
        .NW(NW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .s_in   (s_in),
        .busy   (busy),
        .done   (done),
        .n_out  (n_out),
        .rem_out(rem_out),
        .exact  (exact)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fwd_sum(input int n);
        return n * (n + 1) / 2;
    endfunction

    function automatic void model(input int s, output int n, output int r);
        n = 0;
        while (fwd_sum(n + 1) <= s) n++;
        r = s - fwd_sum(n);
    endfunction

    // wait (bounded) at falling edges until the DUT is idle
    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input int s);
        exp_t e;
        int n, r;
        wait_idle();
        model(s, n, r);
        e.s = s;
        e.n = n;
        e.rem = r;
        e.ex = (r == 0);
        e.acc_edge = edge_cnt + 1;
        q.push_back(e);
        start = 1'b1;
        s_in = SW'(s);
        @(negedge clk);
        start = 1'b0;
        s_in = SW'($urandom);
    endtask

    // monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("n_out[S=%0d]", e.s), int'(n_out), e.n);
                chk($sformatf("rem_out[S=%0d]", e.s), int'(rem_out), e.rem);
                chk($sformatf("exact[S=%0d]", e.s), int'(exact), e.ex);
                chk($sformatf("latency[S=%0d]", e.s), edge_cnt - e.acc_edge + 1, e.n + 2);
                chk($sformatf("busy_at_done[S=%0d]", e.s), int'(busy), 1);
                chk($sformatf("roundtrip[S=%0d]", e.s), fwd_sum(int'(n_out)) + int'(rem_out), e.s);
                chk($sformatf("rem_le_n[S=%0d]", e.s), int'(int'(rem_out) <= int'(n_out)), 1);
            end
        end
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_n_out", int'(n_out), 0);
        chk("reset_rem_out", int'(rem_out), 0);
        chk("reset_exact", int'(exact), 0);
        rst = 1'b0;

        issue(0);
        issue(10);
        issue(11);
        issue(127);

        issue(36);
        repeat (2) @(negedge clk);
        start = 1'b1;
        s_in = SW'(5);
        @(negedge clk);
        start = 1'b0;

        wait_idle();
        start = 1'b1;
        s_in = SW'(100);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_n_out", int'(n_out), 0);
        chk("abort_rem_out", int'(rem_out), 0);
        chk("abort_exact", int'(exact), 0);
        issue(3);

        for (int s = 0; s < 128; s++) issue(s);

        for (int j = 0; j < 60; j++) begin
            issue(int'($urandom_range(0, 127)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        k = 0;
        while ((q.size() != 0 || busy) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
